// File: rtl/case_stream_ctrl.sv
// Stream controller for ASCII case conversion: accepts NUL-terminated strings,
// converts each byte per a latched mode, buffers results in a FIFO and reports counts.
module case_stream_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] char_count,
    output logic [CNT_W-1:0] conv_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [1:0]    mode_q;
    logic [7:0]    mem_data [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          flush;
    logic [7:0]    conv_byte;
    logic          is_upper;
    logic          is_lower;

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);

    assign is_upper = (in_data >= 8'd65) && (in_data <= 8'd90);
    assign is_lower = (in_data >= 8'd97) && (in_data <= 8'd122);

    always_comb begin
        conv_byte = in_data;
        unique case (mode_q)
            2'b01:   if (is_lower) conv_byte = in_data & 8'hDF;
            2'b10:   if (is_upper) conv_byte = in_data | 8'h20;
            2'b11:   if (is_upper || is_lower) conv_byte = in_data ^ 8'h20;
            default: conv_byte = in_data;
        endcase
    end

    assign in_ready  = (state == S_RUN) && !fifo_full;
    // abort wins over a byte offered on the same edge: nothing is pushed or counted
    assign push      = in_valid && in_ready && !abort;
    assign pop       = out_valid && out_ready;
    assign flush     = abort && ((state == S_RUN) || (state == S_DRAIN));

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 8'h00 : mem_data[rd_ptr];
    assign out_last  = fifo_empty ? 1'b0  : mem_last[rd_ptr];
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= conv_byte;
            mem_last[wr_ptr] <= (in_data == 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mode_q     <= 2'b00;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            char_count <= '0;
            conv_count <= '0;
        end else if (flush) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + ONE_C;
            else if (!push && pop) count <= count - ONE_C;

            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        mode_q     <= mode;
                        char_count <= '0;
                        conv_count <= '0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (push) begin
                        if (in_data == 8'h00) begin
                            state <= S_DRAIN;
                        end else if (char_count != '1) begin
                            char_count <= char_count + 1'b1;
                        end
                        if ((conv_byte != in_data) && (conv_count != '1))
                            conv_count <= conv_count + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty || (pop && count == ONE_C)) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
